encoder_gen: RTL
================

# encoder_gen

Quadrature encoder emulator for the scan path. It produces a programmable A/B pulse train (`encoder`/`encoderb`) at a fixed quarter-phase period, in either direction, for a set number of cycles or continuously. It sits in front of the encoder divider/multiplier and line-trigger logic, so scan triggering can be exercised and calibrated without a physical encoder. Host registers supply the controls.

## Interface
Parameters:
- `PERIOD_MIN`, 2: smallest quarter-phase period in clocks; smaller requests are clamped up to this.

Ports:
- `clk_8m` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: master enable. Low aborts any run immediately.
- `start` in 1: one-cycle start request; honoured only in IDLE with `enable`=1.
- `stop` in 1: one-cycle graceful-stop request; honoured only in RUN.
- `dir` in 1: 0 = forward (A leads B), 1 = reverse (B leads A).
- `quarter_period` in 16: clocks per quadrature quarter-phase.
- `pulse_count` in 32: number of full encoder cycles to emit; 0 = continuous.
- `encoder` out 1: phase A.
- `encoderb` out 1: phase B.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse when a run completes (count reached or graceful stop).
- `cycle_cnt` out 32: full cycles emitted since the last start.

## Operation
- States: IDLE, RUN, DONE. Reset value is IDLE.
- Reset values of outputs: `encoder`=0, `encoderb`=0, `busy`=0, `done`=0, `cycle_cnt`=0. Reset also clears the internal timer, phase, shadow registers and stop flag.
- **IDLE → RUN** on `start`=1 & `enable`=1. Same edge:
  - latch `dir`, `quarter_period` (clamped: values < PERIOD_MIN become PERIOD_MIN) and `pulse_count` into shadow registers;
  - timer ← 0, `cycle_cnt` ← 0, stop flag ← 0.
  - Input changes during RUN are ignored.
- **Phase sequence** {A,B}:
  - forward: 00→10→11→01→00;
  - reverse: 00→01→11→10→00.
  - Phase is 00 at run start.
- **RUN timing:** timer increments every clock. When timer == period−1, timer ← 0 and phase advances one step.
- **Cycle counting:** each transition into phase 00 is one full cycle. `cycle_cnt` increments on that edge and wraps at 2^32 in continuous mode.
- **RUN → DONE** on the edge where phase enters 00 and either:
  - (pulse_count ≠ 0 and cycle_cnt+1 == pulse_count), or
  - the stop flag is set.
- **Stop handling:** `stop` in RUN sets the stop flag. The current cycle finishes before the run ends, so the outputs never leave a partial cycle.
- **DONE:** `done`=1 for exactly one cycle, then IDLE unconditionally. Outputs hold 00 and `cycle_cnt` holds its final value.
- **Abort:** `enable`=0 in any state → IDLE on the next edge, with {A,B} ← 00, `busy` ← 0, no `done` pulse, and `cycle_cnt` holding its value. This may emit a non-Gray step; that is accepted.
- **Simultaneous requests:**
  - `start` and `stop` together in IDLE: start honoured, stop ignored.
  - `start` in RUN or DONE: ignored.
  - `stop` on the same edge as count completion: single DONE, single `done` pulse.

## Timing
- `start` sampled at edge T gives `busy`=1 from cycle T+1.
- First A (forward) or B (reverse) rise is visible at T+1+p, where p is the clamped period.
- Each quarter-phase lasts exactly p clocks; a full cycle is 4p clocks, with a 50 % duty cycle on both phases.
- With pulse_count=N, the final return to 00, `done`=1 and `busy`=0 all occur at cycle T+1+4pN. IDLE follows at T+2+4pN.
- A new `start` is accepted from the IDLE cycle onward, so the minimum gap between runs is one idle clock.
- `cycle_cnt` updates on the same edge as the phase transition into 00.
- Every output is a registered flop; no combinational path runs from input to output.

## Test plan
- **Forward count:** p=2, dir=0, N=3, start at T → {A,B} = 00,10,11,01 repeating, each held 2 clocks. `cycle_cnt` steps 1,2,3. `done` pulses at T+25, and `busy` is high T+1..T+24.
- **Reverse count:** p=5, dir=1, N=1 → sequence 01,11,10,00, with B rising at T+6 and `done` at T+21.
- **Clamp and shadowing:** `quarter_period`=0, then changed to 100 mid-run, N=2 → the quarter period stays 2 throughout, and `done` arrives at T+17.
- **Continuous with stop:** N=0, p=3, `stop` pulsed mid-cycle during cycle 5 (`cycle_cnt`=4) → the run completes that cycle, `done` fires as phase returns to 00 with `cycle_cnt`=5, and there is exactly one `done` pulse.
- **Abort:** `enable`=0 while phase=11 → next cycle {A,B}=00, `busy`=0, no `done`, `cycle_cnt` unchanged. A subsequent start restarts from 00 with `cycle_cnt` cleared.
- **Async reset:** `rst_n` low mid-run (between clock edges) → all outputs 0 immediately. After release, `start` behaves exactly as in the forward-count case.

Source files
------------

// File: rtl/encoder_gen.sv
// Quadrature encoder emulator: emits a programmable A/B pulse train for a set
// number of full cycles (or continuously) so scan triggering can run without hardware.
module encoder_gen #(
   parameter int PERIOD_MIN = 2
) (
   input  logic        clk_8m,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        start,
   input  logic        stop,
   input  logic        dir,
   input  logic [15:0] quarter_period,
   input  logic [31:0] pulse_count,
   output logic        encoder,
   output logic        encoderb,
   output logic        busy,
   output logic        done,
   output logic [31:0] cycle_cnt
);

   localparam logic [15:0] PMIN = 16'(PERIOD_MIN);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      r_state;
   logic        r_a;
   logic        r_b;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_cycleCnt;
   logic [15:0] r_timer;
   logic [15:0] r_period;
   logic [31:0] r_pulseCount;
   logic        r_dir;
   logic        r_stopFlag;

   logic [15:0] w_periodClamped;
   logic        w_nextA;
   logic        w_nextB;
   logic        w_tick;
   logic        w_wrap;
   logic [31:0] w_cntNext;
   logic        w_finish;

   assign w_periodClamped = (quarter_period < PMIN) ? PMIN : quarter_period;

   // Reverse direction is the forward sequence with the A and B roles swapped.
   assign w_nextA   = r_dir ? r_b  : ~r_b;
   assign w_nextB   = r_dir ? ~r_a : r_a;
   assign w_tick    = (r_timer == (r_period - 16'd1));
   assign w_wrap    = w_tick && !w_nextA && !w_nextB;
   assign w_cntNext = r_cycleCnt + 32'd1;
   assign w_finish  = w_wrap &&
                      (((r_pulseCount != 32'd0) && (w_cntNext == r_pulseCount)) || r_stopFlag);

   always_ff @(posedge clk_8m or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_a          <= 1'b0;
         r_b          <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_cycleCnt   <= 32'd0;
         r_timer      <= 16'd0;
         r_period     <= 16'd0;
         r_pulseCount <= 32'd0;
         r_dir        <= 1'b0;
         r_stopFlag   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (!enable) begin
            r_state <= IDLE;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (start) begin
                     r_state      <= RUN;
                     r_busy       <= 1'b1;
                     r_dir        <= dir;
                     r_period     <= w_periodClamped;
                     r_pulseCount <= pulse_count;
                     r_timer      <= 16'd0;
                     r_cycleCnt   <= 32'd0;
                     r_stopFlag   <= 1'b0;
                     r_a          <= 1'b0;
                     r_b          <= 1'b0;
                  end
               end
               RUN: begin
                  if (stop) begin
                     r_stopFlag <= 1'b1;
                  end
                  if (w_tick) begin
                     r_timer <= 16'd0;
                     r_a     <= w_nextA;
                     r_b     <= w_nextB;
                     // A run may only end on a return to 00 so no partial cycle is emitted.
                     if (w_wrap) begin
                        r_cycleCnt <= w_cntNext;
                        if (w_finish) begin
                           r_state <= DONE;
                           r_busy  <= 1'b0;
                           r_done  <= 1'b1;
                        end
                     end
                  end else begin
                     r_timer <= r_timer + 16'd1;
                  end
               end
               DONE: begin
                  r_state <= IDLE;
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign encoder   = r_a;
   assign encoderb  = r_b;
   assign busy      = r_busy;
   assign done      = r_done;
   assign cycle_cnt = r_cycleCnt;

endmodule
